// File: rtl/ntt_pkg.sv
// ============================================================================
// Module      : ntt_pkg
// Description : Shared sizes, FSM state type and packed per-BU array types
//               for the 8-BU NTT write-back address path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

   localparam int NUM_BU  = 8;   // butterfly units == BRAM banks
   localparam int CORE_AW = 8;   // core coefficient address width
   localparam int ADW     = 5;   // per-bank local address width
   localparam int BANK_IW = 3;   // bank index width

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } wr_state_t;

   typedef logic [NUM_BU-1:0][CORE_AW-1:0] addr_arr_t;
   typedef logic [NUM_BU-1:0][BANK_IW-1:0] idx_arr_t;
   typedef logic [NUM_BU-1:0][ADW-1:0]     loc_arr_t;
   typedef logic [NUM_BU-1:0][BANK_IW-1:0] sel_arr_t;

endpackage

`default_nettype wire

// File: rtl/bank_addr_split.sv
// ============================================================================
// Module      : bank_addr_split
// Description : Combinational split of a core coefficient address into its
//               bank index (upper bits) and bank-local address (lower bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_addr_split #(
   parameter int CORE_AW = 8,
   parameter int ADW     = 5
) (
   input  logic [CORE_AW-1:0]     i_addr,
   output logic [CORE_AW-ADW-1:0] o_bank,
   output logic [ADW-1:0]         o_local
);

   assign o_bank  = i_addr[CORE_AW-1:ADW];
   assign o_local = i_addr[ADW-1:0];

endmodule

`default_nettype wire

// File: rtl/bram_decode_write.sv
// ============================================================================
// Module      : bram_decode_write
// Description : Write-back address decoder for the 8-BU NTT datapath. Delays
//               the per-BU read addresses by the butterfly latency, derives
//               port-B addresses, and produces per-bank write enables, local
//               addresses and crossbar BU-select codes (lowest BU wins a bank).
//               Optional macro BRAM_WRITE_CONFLICT_CHECK_EN adds a sticky
//               bank-conflict flag; without it conflict_o is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_decode_write
   import ntt_pkg::*;
#(
   parameter int LAT     = 4,
   parameter int NUM_BU  = 8,
   parameter int CORE_AW = 8,
   parameter int ADW     = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      valid_i,
   input  logic                      last_i,
   input  logic [NUM_BU*CORE_AW-1:0] addr_core_i,
   input  logic [CORE_AW-1:0]        olen_i,
   output logic [NUM_BU-1:0]         wen_a_o,
   output logic [NUM_BU-1:0]         wen_b_o,
   output logic [NUM_BU*ADW-1:0]     waddr_a_o,
   output logic [NUM_BU*ADW-1:0]     waddr_b_o,
   output logic [NUM_BU*BANK_IW-1:0] wsel_a_o,
   output logic [NUM_BU*BANK_IW-1:0] wsel_b_o,
   output logic                      busy_o,
   output logic                      done_write_o,
   output logic                      conflict_o
);

   localparam int             c_CNT_W   = $clog2(LAT + 1);
   localparam [c_CNT_W-1:0]   c_LAT_CNT = c_CNT_W'(LAT);
   localparam [c_CNT_W-1:0]   c_ONE     = c_CNT_W'(1);

   // Delay line: LAT-1 raw-input stages, then a split stage and the output
   // register, so a beat sampled at edge N drives the outputs from edge N+LAT.
   logic                r_sr_v [LAT-1];
   addr_arr_t           r_sr_a [LAT-1];
   logic [CORE_AW-1:0]  r_sr_o [LAT-1];

   addr_arr_t           w_addr_a;
   addr_arr_t           w_addr_b;
   idx_arr_t            w_bank_a, w_bank_b;
   loc_arr_t            w_loc_a,  w_loc_b;

   logic                r_dv;
   idx_arr_t            r_bank_a, r_bank_b;
   loc_arr_t            r_loc_a,  r_loc_b;

   logic [NUM_BU-1:0]   w_wen_a, w_wen_b;
   loc_arr_t            w_waddr_a, w_waddr_b;
   sel_arr_t            w_wsel_a, w_wsel_b;

   logic [NUM_BU-1:0]   r_wen_a, r_wen_b;
   loc_arr_t            r_waddr_a, r_waddr_b;
   sel_arr_t            r_wsel_a, r_wsel_b;

   wr_state_t           r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_busy;
   logic                r_done;

   // Shift every beat (valid or not) down the latency-matching delay line
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int s = 0; s < LAT-1; s++) begin
            r_sr_v[s] <= 1'b0;
            r_sr_a[s] <= '0;
            r_sr_o[s] <= '0;
         end
      end else begin
         r_sr_v[0] <= valid_i;
         r_sr_a[0] <= addr_core_i;
         r_sr_o[0] <= olen_i;
         for (int s = 1; s < LAT-1; s++) begin
            r_sr_v[s] <= r_sr_v[s-1];
            r_sr_a[s] <= r_sr_a[s-1];
            r_sr_o[s] <= r_sr_o[s-1];
         end
      end
   end

   assign w_addr_a = r_sr_a[LAT-2];

   generate
      for (genvar k = 0; k < NUM_BU; k++) begin : g_bu
         // Port-B partner sits olen above port A, wrapping modulo 256
         assign w_addr_b[k] = w_addr_a[k] + r_sr_o[LAT-2];

         bank_addr_split #(.CORE_AW(CORE_AW), .ADW(ADW)) u_split_a (
            .i_addr  (w_addr_a[k]),
            .o_bank  (w_bank_a[k]),
            .o_local (w_loc_a[k])
         );

         bank_addr_split #(.CORE_AW(CORE_AW), .ADW(ADW)) u_split_b (
            .i_addr  (w_addr_b[k]),
            .o_bank  (w_bank_b[k]),
            .o_local (w_loc_b[k])
         );
      end
   endgenerate

   // Register the split bank/local fields of the oldest beat
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_dv     <= 1'b0;
         r_bank_a <= '0;
         r_bank_b <= '0;
         r_loc_a  <= '0;
         r_loc_b  <= '0;
      end else begin
         r_dv     <= r_sr_v[LAT-2];
         r_bank_a <= w_bank_a;
         r_bank_b <= w_bank_b;
         r_loc_a  <= w_loc_a;
         r_loc_b  <= w_loc_b;
      end
   end

`ifdef BRAM_WRITE_CONFLICT_CHECK_EN
   logic w_conf;
`endif

   // Per-bank priority select; scanning BUs high to low lets the lowest k win
   always_comb begin
      w_wen_a   = '0;
      w_wen_b   = '0;
      w_waddr_a = '0;
      w_waddr_b = '0;
      w_wsel_a  = '0;
      w_wsel_b  = '0;
`ifdef BRAM_WRITE_CONFLICT_CHECK_EN
      w_conf    = 1'b0;
`endif
      for (int j = 0; j < NUM_BU; j++) begin
         for (int k = NUM_BU-1; k >= 0; k--) begin
            if (r_dv && (r_bank_a[k] == BANK_IW'(j))) begin
`ifdef BRAM_WRITE_CONFLICT_CHECK_EN
               if (w_wen_a[j]) w_conf = 1'b1;
`endif
               w_wen_a[j]   = 1'b1;
               w_waddr_a[j] = r_loc_a[k];
               w_wsel_a[j]  = BANK_IW'(k);
            end
            if (r_dv && (r_bank_b[k] == BANK_IW'(j))) begin
`ifdef BRAM_WRITE_CONFLICT_CHECK_EN
               if (w_wen_b[j]) w_conf = 1'b1;
`endif
               w_wen_b[j]   = 1'b1;
               w_waddr_b[j] = r_loc_b[k];
               w_wsel_b[j]  = BANK_IW'(k);
            end
         end
      end
   end

   // Output register feeding the BRAM ports and the write-data crossbar
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_wen_a   <= '0;
         r_wen_b   <= '0;
         r_waddr_a <= '0;
         r_waddr_b <= '0;
         r_wsel_a  <= '0;
         r_wsel_b  <= '0;
      end else begin
         r_wen_a   <= w_wen_a;
         r_wen_b   <= w_wen_b;
         r_waddr_a <= w_waddr_a;
         r_waddr_b <= w_waddr_b;
         r_wsel_a  <= w_wsel_a;
         r_wsel_b  <= w_wsel_b;
      end
   end

`ifdef BRAM_WRITE_CONFLICT_CHECK_EN
   logic r_conflict;

   // Sticky conflict flag, raised on the same edge as the offending strobe
   always_ff @(posedge clk_i) begin
      if (!rst_i) r_conflict <= 1'b0;
      else if (r_dv && w_conf) r_conflict <= 1'b1;
   end

   assign conflict_o = r_conflict;
`else
   assign conflict_o = 1'b0;
`endif

   // Stage FSM: tracks the last beat through the pipe and times done_write_o
   // so it lands one cycle after that beat's write strobe
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (valid_i) begin
                  r_busy <= 1'b1;
                  if (last_i) begin
                     r_state <= DRAIN;
                     r_cnt   <= c_LAT_CNT;
                  end else begin
                     r_state <= ACTIVE;
                  end
               end
            end
            ACTIVE: begin
               if (valid_i && last_i) begin
                  r_state <= DRAIN;
                  r_cnt   <= c_LAT_CNT;
               end
            end
            DRAIN, DONE: begin
               if (valid_i) begin
                  // A fresh beat reopens the stage and cancels the pending done
                  r_busy <= 1'b1;
                  if (last_i) begin
                     r_state <= DRAIN;
                     r_cnt   <= c_LAT_CNT;
                  end else begin
                     r_state <= ACTIVE;
                     r_cnt   <= '0;
                  end
               end else if (r_state == DRAIN) begin
                  r_cnt <= r_cnt - c_ONE;
                  if (r_cnt == c_ONE) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign wen_a_o      = r_wen_a;
   assign wen_b_o      = r_wen_b;
   assign waddr_a_o    = r_waddr_a;
   assign waddr_b_o    = r_waddr_b;
   assign wsel_a_o     = r_wsel_a;
   assign wsel_b_o     = r_wsel_b;
   assign busy_o       = r_busy;
   assign done_write_o = r_done;

endmodule

`default_nettype wire
